// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional zero-divisor short-cut is enabled with SEQ_DIVIDER_ZERO_CHK_EN.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Step counter only has to reach n-1, so $clog2(n) bits suffice.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// try to subtract the divisor, keep the difference only if it is non-negative.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_bit_o
);

    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, divisor_i};

    // A restore only happens when shifted < divisor < 2^N, so its top bit is zero.
    assign q_bit_o = ~trial[N];
    assign rem_o   = trial[N] ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_ZERO_CHK_EN to add div_by_zero and a one-edge zero-divisor path.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    output logic         div_by_zero,
`endif
    output state_e       state_dbg
);

    localparam int CW = cnt_w(N);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   step_rem;
    logic           step_bit;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    logic           dbz_q, dbz_d;
`endif

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (q_q[N-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; in_valid is looked at only in IDLE, out_ready only in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d   = divisor;
                    q_d     = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                q_d   = {q_q[N-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = rem_q;
    assign state_dbg = state_q;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider at N=8 and N=16.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int N = 8;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 9;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] dividend, divisor, quotient, remainder;
  state_e       state_dbg;
  logic         in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]  dividend16, divisor16, quotient16, remainder16;
  state_e       state_dbg16;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
  logic         div_by_zero, div_by_zero16;
`endif

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    .div_by_zero(div_by_zero),
`endif
    .state_dbg(state_dbg)
  );

  seq_divider #(.N(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .quotient(quotient16), .remainder(remainder16),
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    .div_by_zero(div_by_zero16),
`endif
    .state_dbg(state_dbg16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // lat counts rising edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output int lat, output logic dbz);
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    dbz = div_by_zero;
`else
    dbz = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_div16(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r, output int lat);
    @(negedge clk);
    dividend16 = a;
    divisor16  = b;
    in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    q = quotient16;
    r = remainder16;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [N-1:0] q, r, a, b;
    logic [15:0]  q16, r16, a16, b16;
    logic [2*N-1:0] exp;
    logic dbz;
    int lat;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   9};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   9};
    vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   9};
    vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77,  ZLAT};
    vecs[5] = '{8'd100, 8'd10,  8'd10,  8'd0,   9};
    vecs[6] = '{8'd1,   8'd255, 8'd0,   8'd1,   9};
    vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   9};
    vecs[8] = '{8'd254, 8'd255, 8'd0,   8'd254, 9};
    vecs[9] = '{8'd0,   8'd0,   8'd255, 8'd0,   ZLAT};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; dividend16 = '0; divisor16 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_quotient",  32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_state",     32'(state_dbg), 32'(IDLE));
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
    check("rst_dbz", {31'b0, div_by_zero}, 0);
`endif
    rst = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].q, vecs[i].r});
      run_div(vecs[i].a, vecs[i].b, q, r, lat, dbz);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_quotient", i),  32'(q), 32'(exp[2*N-1:N]));
      check($sformatf("vec%0d_remainder", i), 32'(r), 32'(exp[N-1:0]));
      check($sformatf("vec%0d_latency", i),   lat, vecs[i].lat);
      check($sformatf("vec%0d_released", i),  {31'b0, out_valid}, 0);
`ifdef SEQ_DIVIDER_ZERO_CHK_EN
      check($sformatf("vec%0d_dbz", i), {31'b0, dbz}, {31'b0, vecs[i].b == 0});
      check($sformatf("vec%0d_dbz_clr", i), {31'b0, div_by_zero}, 0);
`endif
    end

    // backpressure: result held, new operands ignored
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      dividend = 8'd50; divisor = 8'd3; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 1);
      check("bp_quotient",  32'(quotient), 28);
      check("bp_remainder", 32'(remainder), 4);
      check("bp_in_ready",  {31'b0, in_ready}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_released", {31'b0, out_valid}, 0);
    check("bp_idle",     {31'b0, in_ready}, 1);
    check("bp_no_accept_quotient", 32'(quotient), 28);

    // reset in the middle of BUSY
    @(negedge clk);
    dividend = 8'd123; divisor = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;  // early out_ready must not matter in BUSY
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_state_busy", 32'(state_dbg), 32'(BUSY));
    check("mid_out_valid",  {31'b0, out_valid}, 0);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  {31'b0, in_ready}, 1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 0);
    check("mid_rst_quotient",  32'(quotient), 0);
    check("mid_rst_remainder", 32'(remainder), 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(8'd100, 8'd10, q, r, lat, dbz);
    check("post_rst_quotient",  32'(q), 10);
    check("post_rst_remainder", 32'(r), 0);
    check("post_rst_latency",   lat, 9);

    // swept operands, N=8
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_div(a, b, q, r, lat, dbz);
      check("sweep8_quotient",  32'(q), 32'(a / b));
      check("sweep8_invariant", 32'(q) * 32'(b) + 32'(r), 32'(a));
      check("sweep8_rem_lt_div", {31'b0, r < b}, 1);
    end

    // swept operands, N=16
    for (int i = 0; i < 150; i++) begin
      a16 = 16'($urandom_range(0, 65535));
      b16 = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run_div16(a16, b16, q16, r16, lat);
      check("sweep16_quotient",  32'(q16), 32'(a16 / b16));
      check("sweep16_invariant", 32'(q16) * 32'(b16) + 32'(r16), 32'(a16));
      check("sweep16_rem_lt_div", {31'b0, r16 < b16}, 1);
      check("sweep16_latency", lat, 17);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
